alu_flag_unit: RTL and testbench

- Consumer end of the ALU result interface.
- Captures the ALU result and overflow for each retiring EX-stage instruction and maintains the architectural flag register {Z, V, N}.
- Evaluates the 3-bit branch condition for B/BR in decode.
- Sits between the EX-stage ALU and the ID-stage branch logic of the 16-bit pipelined CPU.

---
 rtl/alu_flag_unit.sv | 140 ++++++++++++++
 tb/tb_alu_flag_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_unit.sv
// -----------------------------------------------------------------------------
// alu_flag_unit
//
// Purpose:
//   Consumer end of the EX-stage ALU result interface. Keeps the architectural
//   flag register {Z, V, N} up to date for each retiring EX instruction and
//   resolves the 3-bit branch condition for B/BR instructions in ID.
//
// Handshake:
//   There is no back-pressure. An EX instruction updates the flags on the
//   rising edge exactly when alu_valid is high and neither stall nor flush is
//   asserted (and rst is low). take_branch is meaningful only while
//   branch_eval is high and is forced to 0 otherwise.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset, clears the flags
//   alu_valid    EX holds an instruction with a valid ALU result
//   opcode       4-bit opcode of the EX instruction
//   alu_result   WIDTH-bit ALU output
//   alu_ovfl     ALU overflow indication
//   stall        pipeline hold, blocks any flag update
//   flush        EX instruction squashed, blocks any flag update
//   branch_eval  a B/BR is being resolved in ID this cycle
//   cond         branch condition code
//   flags        registered {Z, V, N}
//   take_branch  combinational branch decision
//
// Parameters:
//   WIDTH   datapath width of alu_result
//   BYPASS  1: branch sees the flags being written this cycle
//           0: branch sees only the registered flags
// -----------------------------------------------------------------------------
module alu_flag_unit #(
  parameter int WIDTH  = 16,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovfl,
  input  logic             stall,
  input  logic             flush,
  input  logic             branch_eval,
  input  logic [2:0]       cond,
  output logic [2:0]       flags,
  output logic             take_branch
);

  // Opcodes that touch the flags.
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  // Branch condition codes.
  localparam logic [2:0] CC_NE  = 3'b000;
  localparam logic [2:0] CC_EQ  = 3'b001;
  localparam logic [2:0] CC_GT  = 3'b010;
  localparam logic [2:0] CC_LT  = 3'b011;
  localparam logic [2:0] CC_GE  = 3'b100;
  localparam logic [2:0] CC_LE  = 3'b101;
  localparam logic [2:0] CC_OVF = 3'b110;

  // Flag bit positions inside {Z, V, N}.
  localparam int FZ = 2;
  localparam int FV = 1;
  localparam int FN = 0;

  logic       upd;
  logic       res_zero;
  logic [2:0] nf;
  logic [2:0] ef;
  logic       cond_true;

  assign upd      = alu_valid & ~stall & ~flush & ~rst;
  assign res_zero = (alu_result == '0);

  // Next-flag value: start from the held flags and overwrite only the bits
  // the current opcode is allowed to change.
  always_comb begin
    nf = flags;
    if (upd) begin
      unique case (opcode)
        OP_ADD, OP_SUB: begin
          nf[FZ] = res_zero;
          nf[FV] = alu_ovfl;
          nf[FN] = alu_result[WIDTH-1];
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
          nf[FZ] = res_zero;
        end
        default: begin
          nf = flags;
        end
      endcase
    end
  end

  // Flag set seen by the branch comparator.
  generate
    if (BYPASS) begin : g_bypass
      assign ef = nf;
    end else begin : g_no_bypass
      assign ef = flags;
    end
  endgenerate

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      CC_NE:   cond_true = ~ef[FZ];
      CC_EQ:   cond_true = ef[FZ];
      CC_GT:   cond_true = ~ef[FZ] & ~ef[FN];
      CC_LT:   cond_true = ef[FN];
      // Z=1 or (Z=0 and N=0) reduces to Z | ~N.
      CC_GE:   cond_true = ef[FZ] | ~ef[FN];
      CC_LE:   cond_true = ef[FN] | ef[FZ];
      CC_OVF:  cond_true = ef[FV];
      default: cond_true = 1'b1;
    endcase
  end

  assign take_branch = branch_eval & cond_true;

  // Flag register. When upd is low nf equals flags, so the register simply
  // holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 3'b000;
    end else begin
      flags <= nf;
    end
  end

endmodule

// File: tb/tb_alu_flag_unit.sv
module tb_alu_flag_unit;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT signals
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  opcode;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic        stall;
  logic        flush;
  logic        branch_eval;
  logic [2:0]  cond;
  logic [2:0]  flags_b1;
  logic [2:0]  flags_b0;
  logic        take_b1;
  logic        take_b0;

  always #5 clk = ~clk;

  alu_flag_unit #(.WIDTH(16), .BYPASS(1'b1)) dut_b1 (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .opcode(opcode),
    .alu_result(alu_result), .alu_ovfl(alu_ovfl), .stall(stall),
    .flush(flush), .branch_eval(branch_eval), .cond(cond),
    .flags(flags_b1), .take_branch(take_b1)
  );

  alu_flag_unit #(.WIDTH(16), .BYPASS(1'b0)) dut_b0 (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .opcode(opcode),
    .alu_result(alu_result), .alu_ovfl(alu_ovfl), .stall(stall),
    .flush(flush), .branch_eval(branch_eval), .cond(cond),
    .flags(flags_b0), .take_branch(take_b0)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: three named flag bits and the branch table by name.
  // ---------------------------------------------------------------------------
  logic m_z, m_v, m_n;

  function automatic logic cond_holds(input logic [2:0] c, input logic z,
                                      input logic v, input logic n);
    case (c)
      3'd0: return !z;                 // NE
      3'd1: return z;                  // EQ
      3'd2: return !z && !n;           // GT
      3'd3: return n;                  // LT
      3'd4: return z || (!z && !n);    // GE
      3'd5: return n || z;             // LE
      3'd6: return v;                  // OVF
      default: return 1'b1;            // UNCOND
    endcase
  endfunction

  // Model of one cycle: returns the flags after the edge given inputs.
  task automatic model_next(output logic z, output logic v, output logic n);
    z = m_z; v = m_v; n = m_n;
    if (rst) begin
      z = 0; v = 0; n = 0;
    end else if (alu_valid && !stall && !flush) begin
      if (opcode <= 4'd1) begin
        z = (alu_result == 16'd0);
        v = alu_ovfl;
        n = alu_result[15];
      end else if (opcode == 4'd2 || opcode == 4'd4 || opcode == 4'd5 || opcode == 4'd6) begin
        z = (alu_result == 16'd0);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic drive(input logic r, input logic va, input logic [3:0] op,
                       input logic [15:0] res, input logic ov, input logic st,
                       input logic fl, input logic be, input logic [2:0] c);
    rst = r; alu_valid = va; opcode = op; alu_result = res; alu_ovfl = ov;
    stall = st; flush = fl; branch_eval = be; cond = c;
  endtask

  task automatic idle();
    drive(0, 0, 4'd0, 16'd0, 0, 0, 0, 0, 3'd0);
  endtask

  // Applies the currently driven inputs for one cycle, checking both DUTs
  // against the model (take_branch before the edge, flags after it).
  task automatic model_cycle(input string tag);
    logic nz, nv, nn, exp1, exp0;
    model_next(nz, nv, nn);
    // With rst high the branch must see the registered flags.
    if (rst) exp1 = branch_eval && cond_holds(cond, m_z, m_v, m_n);
    else     exp1 = branch_eval && cond_holds(cond, nz, nv, nn);
    exp0 = branch_eval && cond_holds(cond, m_z, m_v, m_n);
    #1;
    check({tag, ".take_b1"}, {2'b00, take_b1}, {2'b00, exp1});
    check({tag, ".take_b0"}, {2'b00, take_b0}, {2'b00, exp0});
    @(posedge clk);
    #1;
    m_z = nz; m_v = nv; m_n = nn;
    check({tag, ".flags_b1"}, flags_b1, {m_z, m_v, m_n});
    check({tag, ".flags_b0"}, flags_b0, {m_z, m_v, m_n});
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        r;
    logic        va;
    logic [3:0]  op;
    logic [15:0] res;
    logic        ov;
    logic        st;
    logic        fl;
    logic        be;
    logic [2:0]  c;
    logic        exp_take1;
    logic        exp_take0;
    logic [2:0]  exp_flags;  // {Z,V,N} after the edge
  } vec_t;

  localparam int NVEC = 22;
  vec_t tbl[NVEC];

  initial begin
    // Reset held two cycles with an ADD of zero in flight.
    tbl[0]  = '{1, 1, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 3'b000};
    tbl[1]  = '{1, 1, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 3'b000};
    tbl[2]  = '{0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd0, 1, 1, 3'b000};
    // SUB 0x8000 with overflow: Z=0 V=1 N=1.
    tbl[3]  = '{0, 1, 4'h1, 16'h8000, 1, 0, 0, 0, 3'd0, 0, 0, 3'b011};
    tbl[4]  = '{0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd3, 1, 1, 3'b011};
    tbl[5]  = '{0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd6, 1, 1, 3'b011};
    tbl[6]  = '{0, 0, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd2, 0, 0, 3'b011};
    // XOR zero sets Z only; LLB changes nothing.
    tbl[7]  = '{0, 1, 4'h2, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 3'b111};
    tbl[8]  = '{0, 1, 4'hA, 16'h1234, 1, 0, 0, 0, 3'd0, 0, 0, 3'b111};
    // Clear to 000, then stall / flush / both block an ADD of zero.
    tbl[9]  = '{0, 1, 4'h0, 16'h0001, 0, 0, 0, 0, 3'd0, 0, 0, 3'b000};
    tbl[10] = '{0, 1, 4'h0, 16'h0000, 0, 1, 0, 0, 3'd0, 0, 0, 3'b000};
    tbl[11] = '{0, 1, 4'h0, 16'h0000, 0, 0, 1, 0, 3'd0, 0, 0, 3'b000};
    tbl[12] = '{0, 1, 4'h0, 16'h0000, 0, 1, 1, 0, 3'd0, 0, 0, 3'b000};
    tbl[13] = '{0, 1, 4'h0, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 3'b100};
    // Bypass: flags 000, ADD zero together with EQ branch.
    tbl[14] = '{0, 1, 4'h0, 16'h0001, 0, 0, 0, 0, 3'd0, 0, 0, 3'b000};
    tbl[15] = '{0, 1, 4'h0, 16'h0000, 0, 0, 0, 1, 3'd1, 1, 0, 3'b100};
    // Reset together with a branch: branch uses registered Z=1.
    tbl[16] = '{1, 1, 4'h0, 16'h0001, 1, 0, 0, 1, 3'd1, 1, 1, 3'b000};
    // Shifts and rotate touch Z only; PADDSB and HLT touch nothing.
    tbl[17] = '{0, 1, 4'h4, 16'h0000, 1, 0, 0, 1, 3'd6, 0, 0, 3'b100};
    tbl[18] = '{0, 1, 4'h5, 16'h8000, 1, 0, 0, 1, 3'd3, 0, 0, 3'b000};
    tbl[19] = '{0, 1, 4'h6, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 3'b100};
    tbl[20] = '{0, 1, 4'h7, 16'h8000, 1, 0, 0, 0, 3'd0, 0, 0, 3'b100};
    tbl[21] = '{0, 1, 4'hF, 16'h0000, 1, 0, 0, 1, 3'd0, 0, 0, 3'b100};
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic z, v, n;
    idle();
    m_z = 0; m_v = 0; m_n = 0;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].r, tbl[i].va, tbl[i].op, tbl[i].res, tbl[i].ov,
            tbl[i].st, tbl[i].fl, tbl[i].be, tbl[i].c);
      #1;
      check($sformatf("vec%0d.take_b1", i), {2'b00, take_b1}, {2'b00, tbl[i].exp_take1});
      check($sformatf("vec%0d.take_b0", i), {2'b00, take_b0}, {2'b00, tbl[i].exp_take0});
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.flags_b1", i), flags_b1, tbl[i].exp_flags);
      check($sformatf("vec%0d.flags_b0", i), flags_b0, tbl[i].exp_flags);
    end
    m_z = tbl[NVEC-1].exp_flags[2];
    m_v = tbl[NVEC-1].exp_flags[1];
    m_n = tbl[NVEC-1].exp_flags[0];

    // Condition sweep: set each {Z,V,N} combination, then try every cond
    // with branch_eval high and low while no update happens.
    for (int f = 0; f < 8; f++) begin
      z = f[2]; v = f[1]; n = f[0];
      if (z && n) begin
        drive(0, 1, 4'h0, 16'h8000, v, 0, 0, 0, 3'd0);
        model_cycle("sweep_set_a");
        drive(0, 1, 4'h2, 16'h0000, 0, 0, 0, 0, 3'd0);
        model_cycle("sweep_set_b");
      end else begin
        drive(0, 1, 4'h0, z ? 16'h0000 : (n ? 16'h8000 : 16'h0001), v, 0, 0, 0, 3'd0);
        model_cycle("sweep_set");
      end
      check($sformatf("sweep%0d.flags", f), flags_b1, f[2:0]);
      for (int c = 0; c < 8; c++) begin
        for (int be = 0; be < 2; be++) begin
          drive(0, 0, 4'h0, 16'h0000, 0, 0, 0, be[0], c[2:0]);
          #1;
          check($sformatf("sweep f=%0d c=%0d be=%0d", f, c, be), {2'b00, take_b1},
                {2'b00, be[0] && cond_holds(c[2:0], z, v, n)});
          check($sformatf("sweep0 f=%0d c=%0d be=%0d", f, c, be), {2'b00, take_b0},
                {2'b00, be[0] && cond_holds(c[2:0], z, v, n)});
        end
      end
      @(posedge clk);
      #1;
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 31) == 0,
            $urandom_range(0, 3) != 0,
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0,
            1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)));
      model_cycle($sformatf("rand%0d", k));
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
